// File: rtl/sobel_window_buffer_if.sv
// Pixel-stream input and 3x3 window output bundle of sobel_window_buffer.
// The slave modport is the buffer's view; the master modport is the pixel source / window consumer.
interface sobel_window_buffer_if #(
  parameter int PIXEL_W = 8
);
  logic                 sof;
  logic                 pixel_valid;
  logic [PIXEL_W-1:0]   pixel_in;
  logic [9*PIXEL_W-1:0] window_out;
  logic                 start_calculations;
  logic                 frame_done;

  modport master (
    output sof,
    output pixel_valid,
    output pixel_in,
    input  window_out,
    input  start_calculations,
    input  frame_done
  );

  modport slave (
    input  sof,
    input  pixel_valid,
    input  pixel_in,
    output window_out,
    output start_calculations,
    output frame_done
  );
endinterface

// File: rtl/sobel_window_buffer.sv
// Two-line buffer plus 3x3 window register feeding the Sobel gradient stages.
// Optional macro SOBEL_WINDOW_OUTREG_EN adds one output register stage (latency 2 instead of 1).
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIXEL_W    = 8
) (
  input logic                  clk,
  input logic                  n_rst,
  sobel_window_buffer_if.slave sif
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          accept;
  logic          at_last_col;
  logic          at_last_pixel;
  logic          window_ready;

  // lineA holds row r-2, lineB holds row r-1 at each column.
  logic [PIXEL_W-1:0] line_a [IMG_WIDTH];
  logic [PIXEL_W-1:0] line_b [IMG_WIDTH];
  logic [PIXEL_W-1:0] top_px;
  logic [PIXEL_W-1:0] mid_px;

  logic [PIXEL_W-1:0] win [9];
  logic               strobe_q;
  logic               done_q;
  logic [9*PIXEL_W-1:0] win_flat;

  // sof restarts the raster position on this very cycle.
  assign cur_col       = sif.sof ? '0 : col;
  assign cur_row       = sif.sof ? '0 : row;
  assign accept        = sif.pixel_valid;
  assign at_last_col   = (cur_col == LAST_COL);
  assign at_last_pixel = at_last_col && (cur_row == LAST_ROW);
  assign window_ready  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign top_px = line_a[cur_col];
  assign mid_px = line_b[cur_col];

  // NOTE: the line RAMs carry no reset; every entry is rewritten before a window can read it,
  // and a reset on a memory array would block RAM inference.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_a[cur_col] <= mid_px;
      line_b[cur_col] <= sif.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_pixel ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end else if (sif.sof) begin
      col <= '0;
      row <= '0;
    end
  end

  // The window shifts on every accepted pixel; only interior centres raise the strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= accept && window_ready;
      done_q   <= accept && at_last_pixel;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]     <= win[3*r + 1];
          win[3*r + 1] <= win[3*r + 2];
        end
        win[2] <= top_px;
        win[5] <= mid_px;
        win[8] <= sif.pixel_in;
      end
    end
  end

  // NOTE: every output of an always_comb block is given a value before any loop or branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 9; k++) win_flat[k*PIXEL_W +: PIXEL_W] = win[k];
  end

`ifdef SOBEL_WINDOW_OUTREG_EN
  logic [9*PIXEL_W-1:0] win_out_q;
  logic                 strobe_out_q;
  logic                 done_out_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_out_q    <= '0;
      strobe_out_q <= 1'b0;
      done_out_q   <= 1'b0;
    end else begin
      win_out_q    <= win_flat;
      strobe_out_q <= strobe_q;
      done_out_q   <= done_q;
    end
  end

  assign sif.window_out         = win_out_q;
  assign sif.start_calculations = strobe_out_q;
  assign sif.frame_done         = done_out_q;
`else
  assign sif.window_out         = win_flat;
  assign sif.start_calculations = strobe_q;
  assign sif.frame_done         = done_q;
`endif

endmodule
